// File: rtl/sevenseg_capture_if.sv
// Seven-segment capture bus bundle.
// Purpose: groups the observed display bus (an/seg), the clear control and the
//          recovered frame outputs of sevenseg_capture into one interface.
// Signals:
//   an          anode selects, active-low, bit i = position i
//   seg         cathodes, active-low, bit7 = DP, bits6:0 = g..a
//   clear       synchronous partial-frame discard / timeout restart
//   digits_o    recovered digits, position i in bits [4i+3:4i]
//   dp_o        decimal point lit, per position
//   blank_o     position dark, per position
//   err_o       undecodable pattern, per position
//   frame_valid one-cycle pulse when a new frame is presented
//   stalled     no capture for the configured timeout
// Modports: master = side that drives the display bus and reads the frame,
//           slave  = the capture block itself.
interface sevenseg_capture_if;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        clear;
  logic [15:0] digits_o;
  logic [3:0]  dp_o;
  logic [3:0]  blank_o;
  logic [3:0]  err_o;
  logic        frame_valid;
  logic        stalled;

  modport master (
    output an, seg, clear,
    input  digits_o, dp_o, blank_o, err_o, frame_valid, stalled
  );

  modport slave (
    input  an, seg, clear,
    output digits_o, dp_o, blank_o, err_o, frame_valid, stalled
  );
endinterface

// File: rtl/sevenseg_capture.sv
// Seven-segment display capture.
// Purpose: watches a multiplexed active-low seven-segment bus, waits for each
//          {an,seg} pattern to settle, decodes it back to a BCD digit with
//          DP/blank/error flags and assembles four positions into a frame.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    sevenseg_capture_if.slave (an, seg, clear in; frame outputs out)
// Parameters:
//   STABLE_CYCLES  identical consecutive samples required before acceptance (1..255)
//   TIMEOUT_CYCLES cycles without an accepted capture before stalled (>= 1)
module sevenseg_capture #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  sevenseg_capture_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    RUN_MAX = 8'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  logic [11:0]       obs_q, obs_d;
  logic [7:0]        run_q, run_d;
  logic              done_q, done_d;
  logic [3:0]        seen_q, seen_d;
  logic              pend_q, pend_d;
  logic [3:0][6:0]   shadow_q, shadow_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              stalled_q, stalled_d;
  logic [15:0]       digits_q, digits_d;
  logic [3:0]        dp_q, dp_d;
  logic [3:0]        blank_q, blank_d;
  logic [3:0]        err_q, err_d;
  logic              fv_q, fv_d;

  logic [11:0]       sample;
  logic              changed;
  logic              stable_hit;
  logic              an_ok;
  logic [1:0]        pos;
  logic [3:0]        pos_mask;
  logic              accept;
  logic [3:0]        digit;
  logic              is_blank;
  logic              is_err;
  logic [3:0]        seen_base;
  logic [3:0]        seen_new;

  always_comb begin
    sample     = {bus.an, bus.seg};
    changed    = (sample != obs_q);
    // done_q marks that the current stable pattern has already been acted on,
    // so a saturated run counter does not re-trigger acceptance.
    stable_hit = (run_q == RUN_MAX) && !done_q;

    an_ok    = 1'b1;
    pos      = 2'd0;
    pos_mask = 4'b0000;
    case (obs_q[11:8])
      4'hE:    begin pos = 2'd0; pos_mask = 4'b0001; end
      4'hD:    begin pos = 2'd1; pos_mask = 4'b0010; end
      4'hB:    begin pos = 2'd2; pos_mask = 4'b0100; end
      4'h7:    begin pos = 2'd3; pos_mask = 4'b1000; end
      default: an_ok = 1'b0;
    endcase
    accept = stable_hit && an_ok;

    is_blank = 1'b0;
    is_err   = 1'b0;
    case (obs_q[6:0])
      7'h40:   digit = 4'd0;
      7'h79:   digit = 4'd1;
      7'h24:   digit = 4'd2;
      7'h30:   digit = 4'd3;
      7'h19:   digit = 4'd4;
      7'h12:   digit = 4'd5;
      7'h02:   digit = 4'd6;
      7'h78:   digit = 4'd7;
      7'h00:   digit = 4'd8;
      7'h10:   digit = 4'd9;
      7'h7F:   begin digit = 4'hF; is_blank = 1'b1; end
      default: begin digit = 4'hE; is_err = 1'b1; end
    endcase
  end

  always_comb begin
    obs_d     = sample;
    run_d     = run_q;
    done_d    = done_q;
    shadow_d  = shadow_q;
    tmo_d     = tmo_q;
    pend_d    = 1'b0;
    fv_d      = 1'b0;
    digits_d  = digits_q;
    dp_d      = dp_q;
    blank_d   = blank_q;
    err_d     = err_q;
    seen_new  = 4'b0000;

    if (changed) begin
      run_d  = 8'd1;
      done_d = 1'b0;
    end else begin
      if (run_q < RUN_MAX) run_d = run_q + 8'd1;
      if (stable_hit) done_d = 1'b1;
    end

    // A completed frame is published one edge after its last acceptance;
    // the seen-mask restarts at that same edge.
    if (pend_q) begin
      for (int i = 0; i < 4; i++) begin
        digits_d[4*i +: 4] = shadow_q[i][6:3];
        dp_d[i]            = shadow_q[i][2];
        blank_d[i]         = shadow_q[i][1];
        err_d[i]           = shadow_q[i][0];
      end
      fv_d = 1'b1;
    end
    seen_base = pend_q ? 4'b0000 : seen_q;
    seen_d    = seen_base;

    // clear wins over a same-cycle acceptance, which is simply dropped.
    if (bus.clear) begin
      seen_d = 4'b0000;
      tmo_d  = '0;
    end else if (accept) begin
      shadow_d[pos] = {digit, ~obs_q[7], is_blank, is_err};
      seen_new      = seen_base | pos_mask;
      seen_d        = seen_new;
      pend_d        = (seen_new == 4'hF);
      tmo_d         = '0;
    end else if (tmo_q < TMO_MAX) begin
      tmo_d = tmo_q + TW'(1);
    end

    stalled_d = (tmo_d >= TMO_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs_q     <= '0;
      run_q     <= '0;
      done_q    <= 1'b0;
      seen_q    <= '0;
      pend_q    <= 1'b0;
      shadow_q  <= '0;
      tmo_q     <= '0;
      stalled_q <= 1'b0;
      digits_q  <= 16'hFFFF;
      dp_q      <= 4'h0;
      blank_q   <= 4'hF;
      err_q     <= 4'h0;
      fv_q      <= 1'b0;
    end else begin
      obs_q     <= obs_d;
      run_q     <= run_d;
      done_q    <= done_d;
      seen_q    <= seen_d;
      pend_q    <= pend_d;
      shadow_q  <= shadow_d;
      tmo_q     <= tmo_d;
      stalled_q <= stalled_d;
      digits_q  <= digits_d;
      dp_q      <= dp_d;
      blank_q   <= blank_d;
      err_q     <= err_d;
      fv_q      <= fv_d;
    end
  end

  assign bus.digits_o    = digits_q;
  assign bus.dp_o        = dp_q;
  assign bus.blank_o     = blank_q;
  assign bus.err_o       = err_q;
  assign bus.frame_valid = fv_q;
  assign bus.stalled     = stalled_q;

endmodule
